// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    // Smallest digit count d with 10^d > 2^width.
    function automatic int bcd_digits_needed(input int width);
        longint unsigned lim;
        longint unsigned p;
        int d;
        lim = 64'd1 << width;
        p = 64'd1;
        d = 0;
        while (p <= lim && d < 20) begin
            p = p * 64'd10;
            d++;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin_bcd_conv_if.sv
// Upstream binary stream and downstream BCD stream of the converter.
interface bin_bcd_conv_if #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
);
    logic                  bin_vld;
    logic                  bin_rdy;
    logic [BIN_WIDTH-1:0]  bin_data;
    logic                  signed_mode;
    logic                  bcd_vld;
    logic                  bcd_rdy;
    logic [4*DIGITS-1:0]   bcd_data;
    logic                  bcd_neg;

    modport master (
        output bin_vld, bin_data, signed_mode, bcd_rdy,
        input  bin_rdy, bcd_vld, bcd_data, bcd_neg
    );

    modport slave (
        input  bin_vld, bin_data, signed_mode, bcd_rdy,
        output bin_rdy, bcd_vld, bcd_data, bcd_neg
    );
endinterface

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift {bcd, bin} left by one.
module bcd_dabble_step #(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5
) (
    input  logic [4*DIGITS-1:0]  bcd_i,
    input  logic [BIN_WIDTH-1:0] bin_i,
    output logic [4*DIGITS-1:0]  bcd_o,
    output logic [BIN_WIDTH-1:0] bin_o
);
    logic [4*DIGITS-1:0] adj;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign adj[4*g +: 4] = (bcd_i[4*g +: 4] >= 4'd5) ? bcd_i[4*g +: 4] + 4'd3
                                                        : bcd_i[4*g +: 4];
    end

    assign {bcd_o, bin_o} = {adj[4*DIGITS-2:0], bin_i, 1'b0};
endmodule

// File: rtl/bin_bcd_conv.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock.
module bin_bcd_conv
    import bcd_pkg::*;
#(
    parameter int BIN_WIDTH = 16,
    parameter int DIGITS    = 5,
    parameter bit SIGNED_EN = 1'b0
) (
    input  logic           sclk,
    input  logic           s_rst,
    bin_bcd_conv_if.slave  bus
);
    localparam int CNT_W = $clog2(BIN_WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_WIDTH - 1);

    if (BIN_WIDTH < 4 || BIN_WIDTH > 32 || DIGITS < bcd_digits_needed(BIN_WIDTH)) begin : g_param_chk
        $fatal(1, "bin_bcd_conv: BIN_WIDTH must be 4..32 and 10^DIGITS must exceed 2^BIN_WIDTH");
    end

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BCD_W-1:0]     acc_q, acc_d, res_q, res_d, step_bcd;
    logic [BIN_WIDTH-1:0] mag_q, mag_d, step_mag, load_mag;
    logic                 sign_q, sign_d, neg_q, neg_d, load_neg, accept;

    bcd_dabble_step #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) u_step (
        .bcd_i (acc_q),
        .bin_i (mag_q),
        .bcd_o (step_bcd),
        .bin_o (step_mag)
    );

    // Negating the most-negative value wraps to 2^(BIN_WIDTH-1), the correct magnitude.
    assign load_neg = SIGNED_EN && bus.signed_mode && bus.bin_data[BIN_WIDTH-1];
    assign load_mag = load_neg ? -bus.bin_data : bus.bin_data;

    assign bus.bin_rdy  = (state_q == IDLE) || (state_q == DONE && bus.bcd_rdy);
    assign accept       = bus.bin_vld && bus.bin_rdy;
    assign bus.bcd_vld  = (state_q == DONE);
    assign bus.bcd_data = res_q;
    assign bus.bcd_neg  = neg_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mag_d   = mag_q;
        sign_d  = sign_q;
        res_d   = res_q;
        neg_d   = neg_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = CONV;
                    cnt_d   = '0;
                    acc_d   = '0;
                    mag_d   = load_mag;
                    sign_d  = load_neg;
                end else if (state_q == DONE && bus.bcd_rdy) begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                acc_d = step_bcd;
                mag_d = step_mag;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_IT) begin
                    state_d = DONE;
                    res_d   = step_bcd;
                    neg_d   = sign_q && (step_bcd != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mag_q   <= '0;
            sign_q  <= 1'b0;
            res_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mag_q   <= mag_d;
            sign_q  <= sign_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
        end
    end
endmodule
